// File: rtl/rr_arbiter_mux4.sv
// Round-robin arbiter driving a shared 4:1 mux onto one valid/ready port.
// Each grant moves up to BURST words, then hands priority to the next requester.
module rr_arbiter_mux4 #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       sel,
  output logic [3:0]       grant,
  output logic [3:0]       ack
);
  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nx;
  logic [1:0]      ptr, ptr_nx, sel_nx;
  logic [3:0]      grant_nx;
  logic [CW-1:0]   beat_cnt, beat_nx;
  logic [WIDTH-1:0] data_sel;
  logic            found;
  logic [1:0]      win, idx;

  always_comb begin
    case (sel)
      2'd0:    data_sel = data0;
      2'd1:    data_sel = data1;
      2'd2:    data_sel = data2;
      default: data_sel = data3;
    endcase
  end

  assign out_valid = (state == BUSY) & req[sel];
  assign out_data  = out_valid ? data_sel : '0;
  assign ack       = grant & {4{out_valid & out_ready}};

  // Scan starting at ptr so the most recently released requester comes last.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    sel_nx   = sel;
    grant_nx = grant;
    beat_nx  = beat_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = BUSY;
          sel_nx   = win;
          grant_nx = 4'b0001 << win;
          beat_nx  = '0;
        end
      end
      default: begin
        if (!req[sel] || (out_ready && beat_cnt == CW'(BURST - 1))) begin
          state_nx = IDLE;
          grant_nx = '0;
          ptr_nx   = sel + 2'd1;
        end
        if (out_valid && out_ready)
          beat_nx = beat_cnt + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      sel      <= '0;
      grant    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      sel      <= sel_nx;
      grant    <= grant_nx;
      beat_cnt <= beat_nx;
    end
  end
endmodule

// File: doc/rr_arbiter_mux4.md
Name: rr_arbiter_mux4

Overview:
- Round-robin arbiter and sequencer for the shared 4:1 8-bit multiplexer datapath.
- Four requesters each present an 8-bit word and a request line.
- The block grants one requester at a time, drives the mux select, and moves up to BURST words per grant onto a single valid/ready output port.
- Sits between the requester sources and the downstream consumer of the muxed byte.

Parameters:
- WIDTH, 8, data width of each requester word and of out_data.
- BURST, 4, maximum accepted transfers per grant before forced release (legal range 1..16).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  4  request line per requester; req[i] belongs to data_i.
- data0  input  WIDTH  word from requester 0.
- data1  input  WIDTH  word from requester 1.
- data2  input  WIDTH  word from requester 2.
- data3  input  WIDTH  word from requester 3.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_valid  output  1  out_data valid this cycle.
- out_data  output  WIDTH  muxed word of the granted requester.
- sel  output  2  registered mux select (index of the current or last owner).
- grant  output  4  registered one-hot grant; all zeros when idle.
- ack  output  4  one-cycle pulse on bit sel when a transfer is accepted.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst high at a rising edge) sets:
  - state=IDLE, ptr=0, sel=0, grant=0, beat_cnt=0.
  - Hence out_valid=0, out_data=0, ack=0.
- Reset overrides everything, including mid-burst; any in-flight grant is dropped with no ack.
- State IDLE:
  - If req==0, stay IDLE.
  - Otherwise pick the first set req bit scanning ptr, ptr+1, ... (mod 4).
  - Next edge: sel<=winner, grant<=one-hot(winner), beat_cnt<=0, state<=BUSY.
- State BUSY, output logic (combinational from registered state):
  - out_valid = (state==BUSY) & req[sel].
  - out_data = out_valid ? data[sel] : 0.
  - ack = grant & {4{out_valid & out_ready}}.
- State BUSY, transfer (out_valid & out_ready):
  - beat_cnt increments.
  - If beat_cnt==BURST-1, release.
  - Otherwise stay BUSY; the requester may keep req high for further beats.
- State BUSY, req[sel]==0:
  - Release immediately; no transfer and no ack that cycle.
- Release (at the next edge):
  - state<=IDLE, grant<=0, ptr<=sel+1 (wraps 3→0).
  - sel holds its value.
  - beat_cnt cleared on the next grant.
- Latency:
  - req rising before edge k gives grant and out_valid during cycle k+1.
  - One mandatory IDLE bubble cycle between consecutive grants.
- Backpressure: while out_ready=0 in BUSY, out_valid stays high and out_data tracks data[sel]; neither beat_cnt nor state changes.
- Requests from non-granted requesters are ignored until release; they never preempt.
- Fairness: after requester i is released, it has lowest priority. Any continuously requesting requester is granted within 3 grants.
- data inputs must be stable only while that requester's out_valid is high.
- beat_cnt is ceil(log2(BURST))+1 bits wide so BURST=16 cannot wrap.

Test Plan:
- Use data0=8'h01, data1=8'h02, data2=8'h04, data3=8'h08 throughout.
- Reset then idle: rst=1 for 2 cycles, req=0 → grant=0, sel=0, out_valid=0, out_data=8'h00 for 5 cycles.
- Single requester, full burst: req=4'b0100, out_ready=1 → grant=4'b0100 one cycle after the request edge, sel=2'b10. Then 4 cycles of out_valid=1, out_data=8'h04, ack=4'b0100. Then grant=0 for 1 cycle, then re-grant to requester 2 (only requester).
- Round-robin rotation: req=4'b1111, out_ready=1, BURST=4 → grants in order 0,1,2,3,0. Each grant gives 4 beats with out_data 01, 02, 04, 08 respectively, separated by one bubble.
- Backpressure: requester 1 granted, out_ready=0 for 3 cycles then 1 → out_valid=1 and out_data=8'h02 held. ack=0 and beat_cnt frozen during the stall. Burst completes after 4 accepted beats.
- Early release: requester 3 granted, req[3] drops after 2 accepted beats → grant=0 next edge. ptr=0, so with req=4'b0011 the next grant is requester 0.
- Reset mid-burst: assert rst during beat 2 of a requester-2 grant → next edge grant=0, ptr=0, out_valid=0, no ack. With req=4'b0110 after reset, requester 1 is granted first.
